// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive sequencer for the APB UART.
// Takes the synchronized RXD line and the 16x baud enable. Votes three
// mid-bit samples per bit, assembles 5-8 data bits plus optional parity and
// checks the stop bit. The finished character is held in a one-entry
// register that is drained through a valid/ready handshake.
module uart_rx_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXCLK,
    input  logic       RXD,
    input  logic       CLEAR,
    input  logic [1:0] WLS,
    input  logic       PEN,
    input  logic       EPS,
    output logic [7:0] DOUT,
    output logic       DOUT_VALID,
    input  logic       DOUT_READY,
    output logic       PE,
    output logic       FE,
    output logic       BI,
    output logic       OE,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRKWAIT
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic       samp7_q, samp7_d;
    logic       samp8_q, samp8_d;
    logic [7:0] dataBits_q, dataBits_d;
    logic       parBit_q, parBit_d;

    logic [7:0] dout_q;
    logic       valid_q;
    logic       pe_q;
    logic       fe_q;
    logic       bi_q;
    logic       oe_q;
    logic       busy_q;

    logic       vote;
    logic       midTick;
    logic       wrapTick;
    logic       commit;
    logic [2:0] lastIdx;
    logic [7:0] wordMask;
    logic [7:0] charNew;
    logic       parErr;
    logic       frameErr;
    logic       breakDet;

    // Bit-level decode: majority vote, tick phases and the status of the character being committed
    always_comb begin
        vote     = (samp7_q & samp8_q) | (samp7_q & RXD) | (samp8_q & RXD);
        midTick  = RXCLK && (cnt_q == 4'd9);
        wrapTick = RXCLK && (cnt_q == 4'd15);
        lastIdx  = {1'b0, WLS} + 3'd4;
        wordMask = 8'hFF >> (2'd3 - WLS);
        charNew  = dataBits_q & wordMask;
        parErr   = PEN & (^charNew ^ parBit_q ^ ~EPS);
        frameErr = ~vote;
        breakDet = ~vote & (charNew == 8'h00) & (~PEN | ~parBit_q);
    end

    // Next-state logic for the frame sequencer, bit-phase counter and data assembly
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        samp7_d    = samp7_q;
        samp8_d    = samp8_q;
        dataBits_d = dataBits_q;
        parBit_d   = parBit_q;
        commit     = 1'b0;

        if ((state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}) && RXCLK) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
                samp7_d = RXD;
            end
            if (cnt_q == 4'd8) begin
                samp8_d = RXD;
            end
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = 4'd0;
                idx_d = 3'd0;
                if (RXCLK && !RXD) begin
                    state_d    = ST_START;
                    dataBits_d = 8'h00;
                    parBit_d   = 1'b0;
                end
            end
            ST_START: begin
                if (midTick && vote) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (wrapTick) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (midTick) begin
                    dataBits_d[idx_q] = vote;
                end
                if (wrapTick) begin
                    if (idx_q == lastIdx) begin
                        state_d = PEN ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (midTick) begin
                    parBit_d = vote;
                end
                if (wrapTick) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (midTick) begin
                    commit  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = vote ? ST_IDLE : ST_BRKWAIT;
                end
            end
            ST_BRKWAIT: begin
                cnt_d = 4'd0;
                if (RXD) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Sequencer state register; CLEAR aborts any frame in progress
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= 3'd0;
            samp7_q    <= 1'b1;
            samp8_q    <= 1'b1;
            dataBits_q <= 8'h00;
            parBit_q   <= 1'b0;
        end else if (CLEAR) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= 3'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            samp7_q    <= samp7_d;
            samp8_q    <= samp8_d;
            dataBits_q <= dataBits_d;
            parBit_q   <= parBit_d;
        end
    end

    // Holding register: loads on commit when free, otherwise flags an overrun and keeps the old character
    always_ff @(posedge CLK) begin
        if (!RST) begin
            dout_q  <= 8'h00;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            bi_q    <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else if (CLEAR) begin
            valid_q <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            oe_q   <= 1'b0;
            busy_q <= (state_q != ST_IDLE);
            if (commit) begin
                if (!valid_q || DOUT_READY) begin
                    dout_q  <= charNew;
                    pe_q    <= parErr;
                    fe_q    <= frameErr;
                    bi_q    <= breakDet;
                    valid_q <= 1'b1;
                end else begin
                    oe_q <= 1'b1;
                end
            end else if (valid_q && DOUT_READY) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign DOUT       = dout_q;
    assign DOUT_VALID = valid_q;
    assign PE         = pe_q;
    assign FE         = fe_q;
    assign BI         = bi_q;
    assign OE         = oe_q;
    assign BUSY       = busy_q;

endmodule
